// File: rtl/photon_pkg.sv
// Shared definitions for the photon detector channel controller:
// state encoding, channel count and the sensor-vector helper functions.
package photon_pkg;

    localparam int NUM_CH = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CH1   = 3'd1,
        ST_CH2   = 3'd2,
        ST_CH3   = 3'd3,
        ST_CH4   = 3'd4,
        ST_CH5   = 3'd5,
        ST_CH6   = 3'd6,
        ST_COINC = 3'd7
    } state_t;

    // Number of asserted sensors, 0..NUM_CH.
    function automatic logic [2:0] popcount(input logic [NUM_CH-1:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = c + 3'(v[i]);
        end
        return c;
    endfunction

    // One-based index of the highest asserted sensor, 0 when none is set.
    function automatic logic [2:0] prio_enc(input logic [NUM_CH-1:0] v);
        logic [2:0] p;
        p = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (v[i]) p = 3'(i + 1);
        end
        return p;
    endfunction

    // Actuator pattern for a state: one-hot for a channel, all on for COINC.
    function automatic logic [NUM_CH-1:0] act_decode(input state_t s);
        logic [NUM_CH-1:0] a;
        a = '0;
        case (s)
            ST_IDLE:  a = '0;
            ST_COINC: a = '1;
            default:  a[3'(s) - 3'd1] = 1'b1;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/photon_sync.sv
// Two-flop synchronizer for one asynchronous sensor input; clears to 0 on rst.
module photon_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the input through two flops to resolve metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/photon_fsm.sv
// Six-channel photon detector controller: selects the highest-index active
// sensor, enforces a minimum dwell per channel and flags coincidences.
// Build option: define PHOTON_FSM_SYNC_EN to pass every sensor through a
// 2-flop synchronizer (3-edge sensor-to-state latency instead of 1).
module photon_fsm
    import photon_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int COINC_LIMIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       S1,
    input  logic       S2,
    input  logic       S3,
    input  logic       S4,
    input  logic       S5,
    input  logic       S6,
    output logic       A1,
    output logic       A2,
    output logic       A3,
    output logic       A4,
    output logic       A5,
    output logic       A6,
    output logic [2:0] state
);

    localparam logic [7:0] HOLD_MAX  = 8'(HOLD_CYCLES - 1);
    localparam logic [2:0] COINC_LIM = 3'(COINC_LIMIT);

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] v;
    logic [2:0]        cnt;
    logic [2:0]        top;
    state_t            cur;
    state_t            nxt;
    logic [7:0]        hold;
    logic [7:0]        hold_nxt;
    logic [NUM_CH-1:0] act;

    assign raw = {S6, S5, S4, S3, S2, S1};

`ifdef PHOTON_FSM_SYNC_EN
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sync
        photon_sync u_sync (
            .clk (clk),
            .rst (rst),
            .d   (raw[gi]),
            .q   (v[gi])
        );
    end
`else
    assign v = raw;
`endif

    assign cnt = popcount(v);
    assign top = prio_enc(v);

    // Next-state and dwell-counter evaluation in priority order.
    always_comb begin
        // NOTE: defaults first so every path assigns nxt/hold_nxt; no latch is inferred.
        nxt      = cur;
        hold_nxt = hold;
        if (cnt >= COINC_LIM) begin
            nxt = ST_COINC;
        end else begin
            case (cur)
                ST_IDLE: begin
                    if (top != 3'd0) nxt = state_t'(top);
                end
                ST_COINC: begin
                    nxt = ST_IDLE;
                end
                default: begin
                    if (hold < HOLD_MAX) begin
                        hold_nxt = hold + 8'd1;
                    end else if (top == 3'd0) begin
                        nxt = ST_IDLE;
                    end else if (state_t'(top) != cur) begin
                        nxt = state_t'(top);
                    end
                end
            endcase
        end
        if (nxt != cur) hold_nxt = '0;
    end

    // State, dwell counter and actuator register; actuators are decoded from
    // the next state so they always match the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur  <= ST_IDLE;
            hold <= '0;
            act  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            cur  <= nxt;
            hold <= hold_nxt;
            act  <= act_decode(nxt);
        end
    end

    assign state = cur;
    assign {A6, A5, A4, A3, A2, A1} = act;

endmodule

// File: tb/tb_photon_fsm.sv
// Self-checking bench for photon_fsm: a dwell/priority reference model
// compared every cycle, plus directed literal expectations.
module tb_photon_fsm;

    localparam int HOLD = 4;
    localparam int CLIM = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] sv  = 6'b101101;
    logic       a1, a2, a3, a4, a5, a6;
    logic [2:0] st;
    logic [5:0] av;

    int errors = 0;
    int checks = 0;

    photon_fsm #(.HOLD_CYCLES(HOLD), .COINC_LIMIT(CLIM)) dut (
        .clk   (clk),
        .rst   (rst),
        .S1    (sv[0]),
        .S2    (sv[1]),
        .S3    (sv[2]),
        .S4    (sv[3]),
        .S5    (sv[4]),
        .S6    (sv[5]),
        .A1    (a1),
        .A2    (a2),
        .A3    (a3),
        .A4    (a4),
        .A5    (a5),
        .A6    (a6),
        .state (st)
    );

    assign av = {a6, a5, a4, a3, a2, a1};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got state=%0d A=%b, expected state=%0d A=%b",
                     name, act[8:6], act[5:0], exp[8:6], exp[5:0]);
        end
    endtask

    function automatic logic [5:0] exp_act(input int s);
        if (s == 0) return 6'b000000;
        if (s == 7) return 6'b111111;
        return 6'(1 << (s - 1));
    endfunction

    // Reference model: tracks the edge on which the current state was entered
    // and lets a channel be left once HOLD edges have passed since then.
    int         m_st = 0;
    int         m_entry = 0;
    int         edge_n = 0;
    logic [5:0] d1 = '0;
    logic [5:0] d2 = '0;

    always @(posedge clk or posedge rst) begin
        logic [5:0] vu;
        int         n1;
        int         tp;
        int         ns;
        if (rst) begin
            m_st    = 0;
            m_entry = edge_n;
            d1      = '0;
            d2      = '0;
        end else begin
            edge_n++;
`ifdef PHOTON_FSM_SYNC_EN
            vu = d2;
            d2 = d1;
            d1 = sv;
`else
            vu = sv;
`endif
            n1 = $countones(vu);
            tp = 0;
            for (int i = 0; i < 6; i++) if (vu[i]) tp = i + 1;
            if (n1 >= CLIM)                   ns = 7;
            else if (m_st == 0)               ns = tp;
            else if (m_st == 7)               ns = 0;
            else if (edge_n - m_entry < HOLD) ns = m_st;
            else                              ns = tp;
            if (ns != m_st) begin
                m_st    = ns;
                m_entry = edge_n;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model", {st, av}, {3'(m_st), exp_act(m_st)});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input int s);
        check(name, {st, av}, {3'(s), exp_act(s)});
    endtask

    initial begin
        // Reset holds state at IDLE before any edge, with sensors active.
        #1;
        lit("reset_immediate", 0);
        tick();
        tick();
        lit("reset_hold", 0);
        sv  = 6'b000000;
        rst = 1'b0;
        tick();
        lit("idle_quiet", 0);

`ifdef PHOTON_FSM_SYNC_EN
        sv = 6'b100000;
        tick();
        lit("sync_edge1", 0);
        tick();
        lit("sync_edge2", 0);
        tick();
        lit("sync_edge3", 6);
        sv = 6'b000000;
        repeat (HOLD + 3) tick();
        lit("sync_back_idle", 0);
`else
        // Single channel entry and dwell before returning to IDLE.
        sv = 6'b001000;
        tick();
        lit("ch4_entry", 4);
        sv = 6'b000000;
        for (int i = 0; i < HOLD - 1; i++) begin
            tick();
            lit("ch4_dwell", 4);
        end
        tick();
        lit("ch4_expire", 0);

        // Higher channel appears mid-dwell; switch only after expiry.
        sv = 6'b001000;
        tick();
        lit("prio_entry", 4);
        tick();
        sv = 6'b011000;
        tick();
        lit("prio_hold_a", 4);
        tick();
        lit("prio_hold_b", 4);
        tick();
        lit("prio_switch", 5);

        // Coincidence mid-dwell, then IDLE, then re-evaluation.
        sv = 6'b011010;
        tick();
        lit("coinc_enter", 7);
        sv = 6'b011000;
        tick();
        lit("coinc_exit", 0);
        tick();
        lit("coinc_reeval", 5);

        // Full saturation and release.
        sv = 6'b111111;
        tick();
        lit("all_on", 7);
        sv = 6'b000000;
        tick();
        lit("all_off", 0);

        // Asynchronous reset aborts a dwell without a clock edge.
        sv = 6'b000100;
        tick();
        lit("ch3_entry", 3);
        #2;
        rst = 1'b1;
        #1;
        lit("reset_mid_dwell", 0);
        tick();
        rst = 1'b0;
        sv  = 6'b000000;
        tick();
        lit("after_reset", 0);

        // Lowest channel alone, then two sensors below the coincidence limit.
        sv = 6'b000001;
        tick();
        lit("ch1_entry", 1);
        sv = 6'b100001;
        repeat (HOLD) tick();
        lit("ch1_to_ch6", 6);
        sv = 6'b000000;
        repeat (HOLD + 1) tick();
        lit("final_idle", 0);
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
